// File: rtl/parking_gate_controller_pkg.sv
// Shared parking definitions: slot geometry, gate FSM states and a
// lowest-free-slot priority encoder reused by the slot-manager side.
package parking_gate_controller_pkg;

    localparam int unsigned NUM_SLOTS = 4;
    localparam int unsigned SW        = $clog2(NUM_SLOTS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_CHECK,
        ST_OPEN,
        ST_COMMIT,
        ST_DENY,
        ST_RELEASE,
        ST_WAIT_CLEAR
    } gate_state_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [SW-1:0] lowest_set(input logic [NUM_SLOTS-1:0] v);
        logic [SW-1:0] idx;
        idx = '0;
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (v[i]) idx = SW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/parking_gate_controller_debounce.sv
// Counts consecutive high entry samples while the controller is listening
// and strobes once the required run length is reached.
module parking_gate_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic sample,
    output logic arrival_c
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;

    assign arrival_c = run && sample && (cnt == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (run && sample && !arrival_c) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier controller: debounces arrivals, assigns the lowest free
// slot, times the barrier and commits park/release requests to the manager.
module parking_gate_controller
    import parking_gate_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = 4,
    parameter int unsigned GATE_OPEN_CYCLES = 16,
    parameter int unsigned DENY_CYCLES      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 car_at_entry,
    input  logic                 car_passed,
    input  logic                 car_at_exit,
    input  logic [SW-1:0]        exit_slot,
    input  logic [NUM_SLOTS-1:0] slot_available,
    input  logic                 lot_full,
    input  logic                 buzzer,
    input  logic                 park_ack,
    input  logic                 release_ack,
    output logic                 gate_open,
    output logic                 deny,
    output logic [NUM_SLOTS-1:0] guidance,
    output logic                 park_req,
    output logic [SW-1:0]        park_slot,
    output logic                 release_req,
    output logic [SW-1:0]        release_slot,
    output logic                 exit_err,
    output logic [7:0]           entries_total,
    output logic [7:0]           denied_total
);

    localparam int unsigned TMAX = (GATE_OPEN_CYCLES > DENY_CYCLES) ? GATE_OPEN_CYCLES : DENY_CYCLES;
    localparam int unsigned TW   = $clog2(TMAX + 1);

    gate_state_t          state, state_n;
    logic [TW-1:0]        timer, timer_n;
    logic [SW-1:0]        asg, asg_n;
    logic [SW-1:0]        rel, rel_n;
    logic [7:0]           entries_n, denied_n;
    logic                 exit_err_n;
    logic                 gate_open_n, deny_n, park_req_n, release_req_n;
    logic [NUM_SLOTS-1:0] guidance_n;
    logic [SW-1:0]        park_slot_n, release_slot_n;
    logic                 deb_run_c;
    logic                 arrival_c;

    parking_gate_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .run       (deb_run_c),
        .sample    (car_at_entry),
        .arrival_c (arrival_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            timer         <= '0;
            asg           <= '0;
            rel           <= '0;
            entries_total <= '0;
            denied_total  <= '0;
            exit_err      <= 1'b0;
            gate_open     <= 1'b0;
            deny          <= 1'b0;
            guidance      <= '0;
            park_req      <= 1'b0;
            park_slot     <= '0;
            release_req   <= 1'b0;
            release_slot  <= '0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            asg           <= asg_n;
            rel           <= rel_n;
            entries_total <= entries_n;
            denied_total  <= denied_n;
            exit_err      <= exit_err_n;
            gate_open     <= gate_open_n;
            deny          <= deny_n;
            guidance      <= guidance_n;
            park_req      <= park_req_n;
            park_slot     <= park_slot_n;
            release_req   <= release_req_n;
            release_slot  <= release_slot_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        asg_n      = asg;
        rel_n      = rel;
        entries_n  = entries_total;
        denied_n   = denied_total;
        exit_err_n = 1'b0;
        deb_run_c  = 1'b0;

        case (state)
            ST_IDLE: begin
                deb_run_c = !car_at_exit && !buzzer;
                if (car_at_exit) begin
                    if (!slot_available[exit_slot]) begin
                        rel_n   = exit_slot;
                        state_n = ST_RELEASE;
                    end else begin
                        exit_err_n = 1'b1;
                        state_n    = ST_WAIT_CLEAR;
                    end
                end else if (car_at_entry && !buzzer) begin
                    state_n = arrival_c ? ST_CHECK : ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                deb_run_c = !buzzer;
                if (buzzer)             state_n = ST_WAIT_CLEAR;
                else if (arrival_c)     state_n = ST_CHECK;
                else if (!car_at_entry) state_n = ST_IDLE;
            end
            ST_CHECK: begin
                timer_n = '0;
                if (buzzer) begin
                    state_n = ST_WAIT_CLEAR;
                end else if (lot_full || (slot_available == '0)) begin
                    if (denied_total != 8'hFF) denied_n = denied_total + 8'd1;
                    state_n = ST_DENY;
                end else begin
                    asg_n   = lowest_set(slot_available);
                    state_n = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (buzzer)                                   state_n = ST_WAIT_CLEAR;
                else if (car_passed)                          state_n = ST_COMMIT;
                else if (timer == TW'(GATE_OPEN_CYCLES - 1))  state_n = ST_WAIT_CLEAR;
                else                                          timer_n = timer + TW'(1);
            end
            ST_COMMIT: begin
                if (park_ack) begin
                    entries_n = entries_total + 8'd1;
                    state_n   = ST_IDLE;
                end
            end
            ST_DENY: begin
                // Hold the sign for the minimum time, then until the car leaves.
                if (timer == TW'(DENY_CYCLES - 1)) begin
                    if (!car_at_entry) state_n = ST_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_RELEASE: begin
                if (release_ack) state_n = ST_WAIT_CLEAR;
            end
            ST_WAIT_CLEAR: begin
                if (!car_at_exit && !car_at_entry) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        gate_open_n    = (state_n == ST_OPEN);
        deny_n         = (state_n == ST_DENY);
        guidance_n     = (state_n == ST_OPEN) ? (NUM_SLOTS'(1) << asg_n) : '0;
        park_req_n     = (state_n == ST_COMMIT);
        park_slot_n    = (state_n == ST_COMMIT) ? asg_n : '0;
        release_req_n  = (state_n == ST_RELEASE);
        release_slot_n = (state_n == ST_RELEASE) ? rel_n : '0;
    end

endmodule

// File: tb/tb_parking_gate_controller.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// every cycle against a transaction-level model of the gate rules.
module tb_parking_gate_controller;

    logic       clk, rst;
    logic       car_at_entry, car_passed, car_at_exit;
    logic [1:0] exit_slot;
    logic [3:0] slot_available;
    logic       lot_full, buzzer, park_ack, release_ack;
    logic       gate_open, deny, park_req, release_req, exit_err;
    logic [3:0] guidance;
    logic [1:0] park_slot, release_slot;
    logic [7:0] entries_total, denied_total;

    int checks   = 0;
    int failures = 0;

    parking_gate_controller dut (
        .clk(clk), .rst(rst),
        .car_at_entry(car_at_entry), .car_passed(car_passed),
        .car_at_exit(car_at_exit), .exit_slot(exit_slot),
        .slot_available(slot_available), .lot_full(lot_full),
        .buzzer(buzzer), .park_ack(park_ack), .release_ack(release_ack),
        .gate_open(gate_open), .deny(deny), .guidance(guidance),
        .park_req(park_req), .park_slot(park_slot),
        .release_req(release_req), .release_slot(release_slot),
        .exit_err(exit_err), .entries_total(entries_total),
        .denied_total(denied_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model phases of a vehicle transaction.
    localparam int P_IDLE = 0, P_SETTLE = 1, P_DECIDE = 2, P_OPEN = 3;
    localparam int P_PARK = 4, P_REFUSE = 5, P_LEAVE = 6, P_CLEAR = 7;

    int m_phase = P_IDLE, m_run = 0, m_age = 0, m_slot = 0, m_rel = 0;
    int m_entries = 0, m_denied = 0;
    bit m_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_step();
        int found;
        m_err = 0;
        if (!rst) begin
            m_phase = P_IDLE; m_run = 0; m_age = 0; m_slot = 0; m_rel = 0;
            m_entries = 0; m_denied = 0;
            return;
        end
        case (m_phase)
            P_IDLE: begin
                if (car_at_exit) begin
                    if (slot_available[exit_slot]) begin m_err = 1; m_phase = P_CLEAR; end
                    else begin m_rel = int'(exit_slot); m_phase = P_LEAVE; end
                end else if (car_at_entry && !buzzer) begin
                    m_run = 1; m_phase = P_SETTLE;
                end
            end
            P_SETTLE: begin
                if (buzzer) m_phase = P_CLEAR;
                else if (!car_at_entry) m_phase = P_IDLE;
                else begin
                    m_run++;
                    if (m_run == 4) m_phase = P_DECIDE;
                end
            end
            P_DECIDE: begin
                m_age = 0;
                if (buzzer) m_phase = P_CLEAR;
                else if (lot_full || slot_available == 4'b0000) begin
                    m_denied = (m_denied < 255) ? m_denied + 1 : 255;
                    m_phase = P_REFUSE;
                end else begin
                    found = 0;
                    for (int i = 0; i < 4; i++)
                        if (slot_available[i] && found == 0) begin m_slot = i; found = 1; end
                    m_phase = P_OPEN;
                end
            end
            P_OPEN: begin
                if (buzzer) m_phase = P_CLEAR;
                else if (car_passed) m_phase = P_PARK;
                else begin
                    m_age++;
                    if (m_age == 16) m_phase = P_CLEAR;
                end
            end
            P_PARK: if (park_ack) begin m_entries = (m_entries + 1) % 256; m_phase = P_IDLE; end
            P_REFUSE: begin
                if (m_age < 8) m_age++;
                if (m_age >= 8 && !car_at_entry) m_phase = P_IDLE;
            end
            P_LEAVE: if (release_ack) m_phase = P_CLEAR;
            default: if (!car_at_exit && !car_at_entry) m_phase = P_IDLE;
        endcase
    endtask

    // Every-cycle comparison against the model, sampled after the edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("m_gate_open",    int'(gate_open),     int'(m_phase == P_OPEN));
            chk("m_deny",         int'(deny),          int'(m_phase == P_REFUSE));
            chk("m_guidance",     int'(guidance),      (m_phase == P_OPEN) ? (1 << m_slot) : 0);
            chk("m_park_req",     int'(park_req),      int'(m_phase == P_PARK));
            chk("m_park_slot",    int'(park_slot),     (m_phase == P_PARK) ? m_slot : 0);
            chk("m_release_req",  int'(release_req),   int'(m_phase == P_LEAVE));
            chk("m_release_slot", int'(release_slot),  (m_phase == P_LEAVE) ? m_rel : 0);
            chk("m_exit_err",     int'(exit_err),      int'(m_err));
            chk("m_entries",      int'(entries_total), m_entries);
            chk("m_denied",       int'(denied_total),  m_denied);
        end
    end

    int gate_cnt, deny_cnt, req_cnt;

    initial begin
        rst = 1'b0; car_at_entry = 0; car_passed = 0; car_at_exit = 0; exit_slot = 0;
        slot_available = 4'b1111; lot_full = 0; buzzer = 0; park_ack = 0; release_ack = 0;
        tick(3);
        chk("rst_gate", int'(gate_open), 0);
        chk("rst_park_req", int'(park_req), 0);
        chk("rst_entries", int'(entries_total), 0);
        rst = 1'b1;
        tick(1);
        chk("post_rst_guidance", int'(guidance), 0);
        chk("post_rst_deny", int'(deny), 0);

        // Park into lowest free slot of 1010.
        slot_available = 4'b1010; car_at_entry = 1;
        tick(4); car_at_entry = 0;
        tick(1);
        chk("t1_guidance", int'(guidance), 2);
        gate_cnt = 0;
        for (int i = 1; i <= 3; i++) begin
            gate_cnt += int'(gate_open);
            if (i == 3) car_passed = 1;
            tick(1);
        end
        car_passed = 0;
        chk("t1_gate_cycles", gate_cnt, 3);
        chk("t1_gate_closed", int'(gate_open), 0);
        chk("t1_park_req", int'(park_req), 1);
        chk("t1_park_slot", int'(park_slot), 1);
        tick(1); park_ack = 1; tick(1); park_ack = 0;
        chk("t1_req_dropped", int'(park_req), 0);
        chk("t1_entries", int'(entries_total), 1);

        // Full lot: deny until entry drops, then saturate the deny counter.
        tick(2);
        lot_full = 1; slot_available = 4'b0000; car_at_entry = 1;
        deny_cnt = 0; gate_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick(1);
            deny_cnt += int'(deny);
            gate_cnt += int'(gate_open);
            if (i == 19) car_at_entry = 0;
        end
        chk("t2_deny_cycles", deny_cnt, 16);
        chk("t2_no_gate", gate_cnt, 0);
        chk("t2_denied", int'(denied_total), 1);
        for (int r = 0; r < 299; r++) begin
            car_at_entry = 1; tick(12); car_at_entry = 0; tick(2);
        end
        chk("t2_denied_sat", int'(denied_total), 255);

        // Timeout without pass-through.
        lot_full = 0; slot_available = 4'b0100; car_at_entry = 1;
        tick(4); car_at_entry = 0;
        gate_cnt = 0; req_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            gate_cnt += int'(gate_open);
            req_cnt  += int'(park_req);
        end
        chk("t3_gate_cycles", gate_cnt, 16);
        chk("t3_no_park_req", req_cnt, 0);
        chk("t3_entries", int'(entries_total), 1);

        // Simultaneous exit and entry: exit first.
        slot_available = 4'b1011; car_at_entry = 1; car_at_exit = 1; exit_slot = 2;
        tick(1);
        chk("t4_release_req", int'(release_req), 1);
        chk("t4_release_slot", int'(release_slot), 2);
        tick(2); release_ack = 1; tick(1); release_ack = 0;
        chk("t4_release_done", int'(release_req), 0);
        car_at_exit = 0;
        tick(8);
        chk("t4_entry_held", int'(gate_open), 0);
        car_at_entry = 0; tick(1);
        car_at_entry = 1; tick(6);
        chk("t4_entry_served", int'(gate_open), 1);
        car_at_entry = 0; car_passed = 1; tick(1);
        car_passed = 0; park_ack = 1; tick(1); park_ack = 0;
        chk("t4_entries", int'(entries_total), 2);

        // Exit request for a slot that is already free.
        exit_slot = 0; car_at_exit = 1;
        tick(1);
        chk("t5_exit_err", int'(exit_err), 1);
        chk("t5_no_release", int'(release_req), 0);
        tick(1);
        chk("t5_err_pulse", int'(exit_err), 0);
        car_at_exit = 0; tick(1);

        // Buzzer during OPEN aborts the transaction.
        car_at_entry = 1; tick(4); car_at_entry = 0; tick(2);
        chk("t6_open", int'(gate_open), 1);
        buzzer = 1; tick(1); buzzer = 0;
        chk("t6_gate_fall", int'(gate_open), 0);
        chk("t6_no_park", int'(park_req), 0);
        tick(2);

        // Reset asserted while a park request is outstanding.
        car_at_entry = 1; tick(4); car_at_entry = 0; tick(2);
        car_passed = 1; tick(1); car_passed = 0;
        chk("t7_in_commit", int'(park_req), 1);
        rst = 0; #1;
        chk("t7_req_async", int'(park_req), 0);
        chk("t7_entries_clr", int'(entries_total), 0);
        chk("t7_denied_clr", int'(denied_total), 0);
        tick(2); rst = 1; tick(1);

        // Randomized traffic.
        for (int c = 0; c < 15000; c++) begin
            if ($urandom_range(7) == 0)  car_at_entry = ~car_at_entry;
            if ($urandom_range(11) == 0) car_at_exit = ~car_at_exit;
            if (!car_at_exit)            exit_slot = 2'($urandom);
            if ($urandom_range(5) == 0)  slot_available = 4'($urandom);
            car_passed  = ($urandom_range(5) == 0);
            park_ack    = ($urandom_range(2) == 0);
            release_ack = ($urandom_range(2) == 0);
            buzzer      = ($urandom_range(24) == 0);
            lot_full    = ($urandom_range(7) == 0);
            if ($urandom_range(2999) == 0) begin
                rst = 0; tick(2); rst = 1;
            end
            tick(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_gate_controller.md
Name: parking_gate_controller

Overview:
- Entry/exit barrier controller at the vehicle-facing end of the parking slot-manager interface.
- Consumes the manager's status outputs: slot_available, lot_full, buzzer.
- Produces the park and release requests that the manager acts on.
- Debounces the entry sensor, picks a free slot, times the barrier and commits the transaction via req/ack handshakes.

Parameters:
- NUM_SLOTS, 4: slot count; slot index width SW = clog2(NUM_SLOTS) = 2.
- DEBOUNCE_CYCLES, 4: consecutive high samples of car_at_entry needed to accept an arrival.
- GATE_OPEN_CYCLES, 16: barrier-open timeout.
- DENY_CYCLES, 8: minimum deny-indicator time.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low; all state cleared while low.
- car_at_entry  in  1  entry loop sensor, synchronous level.
- car_passed  in  1  barrier pass-through sensor, synchronous level.
- car_at_exit  in  1  exit request, synchronous level.
- exit_slot  in  SW  slot being vacated; valid while car_at_exit is high.
- slot_available  in  NUM_SLOTS  1 = slot free, from the slot manager.
- lot_full  in  1  all slots occupied.
- buzzer  in  1  manager alarm.
- park_ack  in  1  manager accepted park_req.
- release_ack  in  1  manager accepted release_req.
- gate_open  out  1  barrier drive.
- deny  out  1  "lot full" sign.
- guidance  out  NUM_SLOTS  one-hot lamp for the assigned slot.
- park_req  out  1  occupy request; held until acked.
- park_slot  out  SW  slot to occupy; stable while park_req is high.
- release_req  out  1  vacate request; held until acked.
- release_slot  out  SW  slot to vacate; stable while release_req is high.
- exit_err  out  1  one-cycle pulse: exit requested for a slot already free.
- entries_total  out  8  committed parks; wraps 255 -> 0.
- denied_total  out  8  denied arrivals; saturates at 255.

Behaviour:
- Reset: rst low asynchronously forces state IDLE and all counters/timers to 0. Every output reads 0 while rst is low and on the first cycle after release.
- States: IDLE, DEBOUNCE, CHECK, OPEN, COMMIT, DENY, RELEASE, WAIT_CLEAR.
- IDLE:
  - Exit has priority. car_at_exit=1 and slot_available[exit_slot]=0: latch release_slot, go to RELEASE.
  - car_at_exit=1 and slot_available[exit_slot]=1: pulse exit_err for 1 cycle, go to WAIT_CLEAR.
  - Otherwise car_at_entry=1 and buzzer=0: go to DEBOUNCE with counter = 1.
- DEBOUNCE:
  - Counter increments each cycle car_at_entry=1.
  - Any low sample returns to IDLE.
  - When the counter reaches DEBOUNCE_CYCLES, go to CHECK. Latency from first high sample to CHECK = DEBOUNCE_CYCLES cycles.
- CHECK (1 cycle):
  - If lot_full=1 or slot_available=0: go to DENY and increment denied_total, saturating.
  - Else latch the lowest-index set bit of slot_available as the assigned slot, drive guidance one-hot, load timer = 0, go to OPEN.
- OPEN:
  - gate_open=1; guidance holds the assigned slot; timer increments each cycle.
  - car_passed=1: go to COMMIT.
  - Timer reaching GATE_OPEN_CYCLES-1 without car_passed: gate closes, assignment dropped, go to WAIT_CLEAR. No park_req, no counter change.
  - car_passed and timeout in the same cycle: car_passed wins.
- COMMIT:
  - gate_open=0, guidance cleared, park_req=1, park_slot = assigned slot.
  - On the cycle park_ack=1 is sampled: entries_total increments (wrapping), park_req drops the next cycle, go to IDLE.
- DENY:
  - deny=1 for at least DENY_CYCLES cycles, then held until car_at_entry=0, then IDLE.
- RELEASE:
  - release_req=1 until release_ack is sampled, then go to WAIT_CLEAR.
- WAIT_CLEAR:
  - Stay until car_at_exit=0 and car_at_entry=0, then IDLE. This prevents one vehicle being serviced twice.
- buzzer=1:
  - In DEBOUNCE, CHECK or OPEN: next cycle go to WAIT_CLEAR, gate_open=0, guidance=0, no commit.
  - COMMIT and RELEASE are unaffected; a handshake in flight always completes.
  - In IDLE: entry blocked; exit still serviced.
- Handshake rule: a req rises only from IDLE/OPEN transitions. Slot and req fields never change while req=1; ack while req=0 is ignored.
- Reset mid-operation: handshake abandoned; the manager sees req fall asynchronously.

Decomposition:
- Shared parking package: state enum, SW derivation, NUM_SLOTS default, and a lowest-set-bit priority-encoder function (reused by the manager side).
- One sub-module is natural: parking_gate_debounce. It holds the DEBOUNCE_CYCLES counter and outputs a qualified arrival strobe.

Test Plan:
- slot_available=4'b1010, entry high 4 cycles, car_passed at cycle 3 of OPEN, park_ack 2 cycles later -> guidance=4'b0010, park_slot=1, gate_open high 3 cycles, entries_total=1.
- lot_full=1, entry held 20 cycles -> deny high from cycle after CHECK until entry drops, no gate_open, denied_total=1; repeated 300 times -> denied_total=255.
- Entry accepted, no car_passed -> gate_open high exactly 16 cycles, then WAIT_CLEAR; park_req never asserted; entries_total unchanged.
- Entry and car_at_exit (exit_slot=2, slot_available[2]=0) asserted together -> release_req with release_slot=2 first; entry serviced only after WAIT_CLEAR.
- car_at_exit with exit_slot=0, slot_available[0]=1 -> exit_err single-cycle pulse, no release_req.
- buzzer raised mid-OPEN -> gate_open falls next cycle, no park_req. rst pulled low during COMMIT -> park_req=0 immediately, counters 0.
